// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver. The 0..15 input is sampled once per frame and shown as tens/units with dead-time between digits.
// Build option: define LEADING_ZERO_BLANK_EN to leave the tens digit dark for values below 10.
//
// state    | meaning
// S_UNITS  | units anode on for SCAN_CYCLES (frame starts here)
// S_BLANK0 | both anodes off for BLANK_CYCLES
// S_TENS   | tens anode on for SCAN_CYCLES
// S_BLANK1 | both anodes off for BLANK_CYCLES (reset state)
module seg7_scan_driver #(
  parameter int SCAN_CYCLES  = 27000,
  parameter int BLANK_CYCLES = 270
) (
  input  logic       clk_pi,
  input  logic       rst_pi,
  input  logic [3:0] cod_bin_pi,
  output logic [1:0] anodo_po,
  output logic [6:0] catodo_po,
  output logic       frame_po
);

  localparam int MAX_CYCLES = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [1:0] S_UNITS  = 2'd0;
  localparam logic [1:0] S_BLANK0 = 2'd1;
  localparam logic [1:0] S_TENS   = 2'd2;
  localparam logic [1:0] S_BLANK1 = 2'd3;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    val_q, val_d;
  logic [1:0]    anodo_q, anodo_d;
  logic [6:0]    catodo_q, catodo_d;
  logic          frame_q, frame_d;

  logic          last_cycle;
  logic [3:0]    units;
  logic          tens;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_OFF;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    val_d      = val_q;
    frame_d    = 1'b0;
    last_cycle = ((state_q == S_UNITS) || (state_q == S_TENS)) ? (cnt_q == SCAN_LAST)
                                                                : (cnt_q == BLANK_LAST);
    if (last_cycle) begin
      cnt_d   = '0;
      state_d = state_q + 2'd1;
      if (state_q == S_BLANK1) begin
        val_d   = cod_bin_pi;
        frame_d = 1'b1;
      end
    end

    // Outputs are decoded from the next state/value so they register on the same edge as the FSM.
    tens  = (val_d >= 4'd10);
    units = tens ? (val_d - 4'd10) : val_d;

    anodo_d  = 2'b11;
    catodo_d = SEG_OFF;
    case (state_d)
      S_UNITS: begin
        anodo_d  = 2'b10;
        catodo_d = seg_code(units);
      end
      S_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (tens) begin
          anodo_d  = 2'b01;
          catodo_d = seg_code(4'd1);
        end
`else
        anodo_d  = 2'b01;
        catodo_d = seg_code({3'b000, tens});
`endif
      end
      default: begin
        anodo_d  = 2'b11;
        catodo_d = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      state_q  <= S_BLANK1;
      cnt_q    <= '0;
      val_q    <= 4'd0;
      anodo_q  <= 2'b11;
      catodo_q <= SEG_OFF;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      anodo_q  <= anodo_d;
      catodo_q <= catodo_d;
      frame_q  <= frame_d;
    end
  end

  assign anodo_po  = anodo_q;
  assign catodo_po = catodo_q;
  assign frame_po  = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-position model checked every cycle plus hand-computed literal points.
module tb_seg7_scan_driver;

  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 2 * (SCAN + BLANK);

  logic       clk_pi;
  logic       rst_pi;
  logic [3:0] cod_bin_pi;
  logic [1:0] anodo_po;
  logic [6:0] catodo_po;
  logic       frame_po;

  int n_vec;
  int n_err;

  logic [6:0] seg_tab [0:9];

  // Model: edges since reset release and the value latched at each frame start.
  int         k_m;
  logic [3:0] lat_m;

  seg7_scan_driver #(.SCAN_CYCLES(SCAN), .BLANK_CYCLES(BLANK)) dut (
    .clk_pi    (clk_pi),
    .rst_pi    (rst_pi),
    .cod_bin_pi(cod_bin_pi),
    .anodo_po  (anodo_po),
    .catodo_po (catodo_po),
    .frame_po  (frame_po)
  );

  initial begin
    clk_pi = 1'b0;
    forever #5 clk_pi = ~clk_pi;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t (k=%0d)", nm, act, exp, $time, k_m);
    end
  endtask

  always @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      k_m   = 0;
      lat_m = 4'd0;
    end else begin
      k_m = k_m + 1;
      if (k_m >= BLANK && ((k_m - BLANK) % FRAME) == 0) lat_m = cod_bin_pi;
    end
  end

  function automatic logic [9:0] model_out(input int k, input logic [3:0] v);
    int ph;
    logic [1:0] an;
    logic [6:0] ca;
    logic       fr;
    an = 2'b11;
    ca = 7'h7F;
    fr = 1'b0;
    if (k >= BLANK) begin
      ph = (k - BLANK) % FRAME;
      fr = (ph == 0);
      if (ph < SCAN) begin
        an = 2'b10;
        ca = seg_tab[(v >= 10) ? int'(v) - 10 : int'(v)];
      end else if (ph >= SCAN + BLANK && ph < 2 * SCAN + BLANK) begin
`ifdef LEADING_ZERO_BLANK_EN
        if (v >= 10) begin
          an = 2'b01;
          ca = seg_tab[1];
        end
`else
        an = 2'b01;
        ca = seg_tab[(v >= 10) ? 1 : 0];
`endif
      end
    end
    return {an, ca, fr};
  endfunction

  always @(negedge clk_pi) begin
    logic [9:0] e;
    e = model_out(k_m, lat_m);
    chk("anodo", 32'(anodo_po), 32'(e[9:8]));
    chk("catodo", 32'(catodo_po), 32'(e[7:1]));
    chk("frame", 32'(frame_po), 32'(e[0]));
    chk("anode_excl", 32'(anodo_po != 2'b00), 32'd1);
  end

  task automatic wait_k(input int n);
    int guard;
    guard = 0;
    while (k_m != n && guard < 2000) begin
      @(negedge clk_pi);
      guard++;
    end
    if (k_m != n) begin
      n_err++;
      $display("FAIL wait_k: reached k=%0d, expected %0d", k_m, n);
    end
  endtask

  task automatic do_reset(input logic [3:0] v);
    @(negedge clk_pi);
    rst_pi     = 1'b0;
    cod_bin_pi = v;
    @(negedge clk_pi);
    rst_pi = 1'b1;
  endtask

  task automatic lit(input string nm, input logic [1:0] an, input logic [6:0] ca, input logic fr);
    chk({nm, ".an"}, 32'(anodo_po), 32'(an));
    chk({nm, ".ca"}, 32'(catodo_po), 32'(ca));
    chk({nm, ".fr"}, 32'(frame_po), 32'(fr));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    cod_bin_pi = 4'd13;
    rst_pi     = 1'b1;
    #1 rst_pi  = 1'b0;
    #1 lit("rst_immediate", 2'b11, 7'h7F, 1'b0);
    repeat (3) @(negedge clk_pi);
    rst_pi = 1'b1;

    // Value 13
    wait_k(1);  lit("v13_k1_blank", 2'b11, 7'h7F, 1'b0);
    wait_k(2);  lit("v13_units_start", 2'b10, 7'h30, 1'b1);
    wait_k(3);  lit("v13_units_2", 2'b10, 7'h30, 1'b0);
    wait_k(9);  lit("v13_units_last", 2'b10, 7'h30, 1'b0);
    wait_k(10); lit("v13_blank0", 2'b11, 7'h7F, 1'b0);
    wait_k(12); lit("v13_tens_start", 2'b01, 7'h79, 1'b0);
    wait_k(19); lit("v13_tens_last", 2'b01, 7'h79, 1'b0);
    wait_k(20); lit("v13_blank1", 2'b11, 7'h7F, 1'b0);
    wait_k(22); lit("v13_frame2", 2'b10, 7'h30, 1'b1);

    // Asynchronous reset in the middle of S_TENS
    wait_k(34); lit("v13_tens_mid", 2'b01, 7'h79, 1'b0);
    #2 rst_pi = 1'b0;
    #1 lit("rst_mid_tens", 2'b11, 7'h7F, 1'b0);
    @(negedge clk_pi);
    rst_pi = 1'b1;

    // Value 7
    do_reset(4'd7);
    wait_k(2);  lit("v7_units", 2'b10, 7'h78, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    wait_k(12); lit("v7_tens_dark", 2'b11, 7'h7F, 1'b0);
`else
    wait_k(12); lit("v7_tens_zero", 2'b01, 7'h40, 1'b0);
`endif
    wait_k(22);

    // Mid-frame change 5 -> 10
    do_reset(4'd5);
    wait_k(4);
    cod_bin_pi = 4'd10;
    wait_k(5);  lit("chg_units_old", 2'b10, 7'h12, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    wait_k(12); lit("chg_tens_old", 2'b11, 7'h7F, 1'b0);
`else
    wait_k(12); lit("chg_tens_old", 2'b01, 7'h40, 1'b0);
`endif
    wait_k(22); lit("chg_units_new", 2'b10, 7'h40, 1'b1);
    wait_k(32); lit("chg_tens_new", 2'b01, 7'h79, 1'b0);

    // Sweep 0..15, one value per frame
    do_reset(4'd0);
    for (int v = 1; v < 16; v++) begin
      wait_k(1 + FRAME * v);
      cod_bin_pi = 4'(v);
    end
    wait_k(2 + FRAME * 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
